// File: rtl/de0_mmio.sv
// rtl/de0_mmio.sv - DE0 memory-mapped I/O block (LED, 7-seg, switches, buttons, timer); optional TIMER via DE0_MMIO_TIMER_EN
module de0_mmio #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
  parameter int          NUM_LEDS        = 10,
  parameter int          NUM_SW          = 10,
  parameter int          NUM_BTN         = 3,
  parameter int          NUM_DIGITS      = 4,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    we,
  output logic [31:0]             rdata,
  output logic                    sel,
  output logic                    ram_we,
  input  logic [NUM_SW-1:0]       switchs,
  input  logic [NUM_BTN-1:0]      buttons,
  output logic [NUM_LEDS-1:0]     leds,
  output logic [8*NUM_DIGITS-1:0] segs
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] OFF_LED      = 6'd0;
  localparam logic [5:0] OFF_HEX      = 6'd1;
  localparam logic [5:0] OFF_HEX_CTRL = 6'd2;
  localparam logic [5:0] OFF_SW       = 6'd3;
  localparam logic [5:0] OFF_BTN      = 6'd4;
  localparam logic [5:0] OFF_BTN_EDGE = 6'd5;
  localparam logic [5:0] OFF_TIMER    = 6'd6;

  logic [5:0] off;
  logic       wr_en;
  logic       unused_bits;

  logic [NUM_LEDS-1:0]         led_q, led_d;
  logic [4*NUM_DIGITS-1:0]     hex_q, hex_d;
  logic [NUM_DIGITS:0]         hex_ctrl_q, hex_ctrl_d;
  logic [NUM_SW-1:0]           sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [NUM_BTN-1:0]          btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [NUM_BTN-1:0]          btn_db_q, btn_db_d;
  logic [NUM_BTN-1:0]          btn_edge_q, btn_edge_d;
  logic [NUM_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NUM_BTN-1:0]          btn_pressed;
`ifdef DE0_MMIO_TIMER_EN
  logic [31:0]                 timer_q, timer_d;
`endif

  assign sel         = (addr[31:8] == BASE_ADDR[31:8]);
  assign ram_we      = we & ~sel;
  assign off         = addr[7:2];
  assign wr_en       = we & sel;
  assign leds        = led_q;
  assign btn_pressed = ~btn_sync_q;
  assign unused_bits = ^{addr[1:0], wdata};

  // Active-low 7-segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b100_0000;
      4'h1: hex7 = 7'b111_1001;
      4'h2: hex7 = 7'b010_0100;
      4'h3: hex7 = 7'b011_0000;
      4'h4: hex7 = 7'b001_1001;
      4'h5: hex7 = 7'b001_0010;
      4'h6: hex7 = 7'b000_0010;
      4'h7: hex7 = 7'b111_1000;
      4'h8: hex7 = 7'b000_0000;
      4'h9: hex7 = 7'b001_0000;
      4'hA: hex7 = 7'b000_1000;
      4'hB: hex7 = 7'b000_0011;
      4'hC: hex7 = 7'b100_0110;
      4'hD: hex7 = 7'b010_0001;
      4'hE: hex7 = 7'b000_0110;
      default: hex7 = 7'b000_1110;
    endcase
  endfunction

  // Next-state: register writes, synchronisers, debounce, edge flags, timer
  always_comb begin
    led_d      = led_q;
    hex_d      = hex_q;
    hex_ctrl_d = hex_ctrl_q;
    sw_meta_d  = switchs;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = buttons;
    btn_sync_d = btn_meta_q;
    btn_db_d   = btn_db_q;
    cnt_d      = cnt_q;

    if (wr_en && off == OFF_LED)      led_d      = wdata[NUM_LEDS-1:0];
    if (wr_en && off == OFF_HEX)      hex_d      = wdata[4*NUM_DIGITS-1:0];
    if (wr_en && off == OFF_HEX_CTRL) hex_ctrl_d = wdata[NUM_DIGITS:0];

    // A change must persist DEBOUNCE_CYCLES consecutive cycles before it is accepted
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_pressed[i] != btn_db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          btn_db_d[i] = ~btn_db_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    // Clear first so a press landing in the same cycle as the W1C still sets the flag
    btn_edge_d = btn_edge_q;
    if (wr_en && off == OFF_BTN_EDGE) btn_edge_d = btn_edge_q & ~wdata[NUM_BTN-1:0];
    btn_edge_d = btn_edge_d | (btn_db_d & ~btn_db_q);

`ifdef DE0_MMIO_TIMER_EN
    timer_d = (wr_en && off == OFF_TIMER) ? wdata : timer_q + 32'd1;
`endif
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      hex_q      <= '0;
      hex_ctrl_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      btn_db_q   <= '0;
      btn_edge_q <= '0;
      cnt_q      <= '0;
`ifdef DE0_MMIO_TIMER_EN
      timer_q    <= '0;
`endif
    end else begin
      led_q      <= led_d;
      hex_q      <= hex_d;
      hex_ctrl_q <= hex_ctrl_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_db_q   <= btn_db_d;
      btn_edge_q <= btn_edge_d;
      cnt_q      <= cnt_d;
`ifdef DE0_MMIO_TIMER_EN
      timer_q    <= timer_d;
`endif
    end
  end

  // Combinational read mux; unused upper bits and unmapped offsets read 0
  always_comb begin
    rdata = '0;
    case (off)
      OFF_LED:      rdata[NUM_LEDS-1:0]     = led_q;
      OFF_HEX:      rdata[4*NUM_DIGITS-1:0] = hex_q;
      OFF_HEX_CTRL: rdata[NUM_DIGITS:0]     = hex_ctrl_q;
      OFF_SW:       rdata[NUM_SW-1:0]       = sw_sync_q;
      OFF_BTN:      rdata[NUM_BTN-1:0]      = btn_db_q;
      OFF_BTN_EDGE: rdata[NUM_BTN-1:0]      = btn_edge_q;
`ifdef DE0_MMIO_TIMER_EN
      OFF_TIMER:    rdata                   = timer_q;
`endif
      default:      rdata = '0;
    endcase
  end

  // Seven-segment drive: blanked when disabled, dp active-low from HEX_CTRL
  always_comb begin
    segs = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (hex_ctrl_q[0]) segs[8*k +: 8] = {~hex_ctrl_q[k+1], hex7(hex_q[4*k +: 4])};
    end
  end

endmodule

// File: tb/tb_de0_mmio.sv
// tb/tb_de0_mmio.sv - scoreboard testbench for de0_mmio
module tb_de0_mmio;

  localparam int DEB = 8;
  localparam logic [31:0] B = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        sel, ram_we;
  logic [9:0]  switchs = '0;
  logic [2:0]  buttons = '1;
  logic [9:0]  leds;
  logic [31:0] segs;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  de0_mmio #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sel(sel), .ram_we(ram_we), .switchs(switchs),
    .buttons(buttons), .leds(leds), .segs(segs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    we   = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    #1;
    check({tag, "_sel"}, {31'd0, sel}, 32'd1);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, all offsets read 0 while held in reset
    tick(2);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_off%0d", i * 4), B + 32'(i * 4), 32'd0);
    check("rst_leds", {22'd0, leds}, 32'd0);
    check("rst_segs", segs, 32'hFFFF_FFFF);
    addr = 32'h0000_0100; we = 1'b1; #1;
    check("rst_out_ram_we", {31'd0, ram_we}, 32'd1);
    check("rst_out_sel", {31'd0, sel}, 32'd0);
    addr = B; #1;
    check("rst_in_ram_we", {31'd0, ram_we}, 32'd0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // LED write: pre-write value visible during the write cycle
    @(negedge clk);
    addr = B; wdata = 32'h3A5; we = 1'b1; #1;
    check("led_prewrite", rdata, 32'd0);
    @(negedge clk);
    we = 1'b0;
    check("leds", {22'd0, leds}, 32'h3A5);
    rd("led_rd", B, 32'h3A5);
    wr("hex", B + 32'h04, 32'h1234);
    check("segs_disabled", segs, 32'hFFFF_FFFF);
    wr("hexctrl", B + 32'h08, 32'h03);
    check("segs_on", segs, 32'hF9A4_B019);
    rd("hex_rd", B + 32'h04, 32'h1234);
    rd("hexctrl_rd", B + 32'h08, 32'h03);
    wr("hexctrl2", B + 32'h08, 32'h11);
    check("segs_dp3", segs, 32'h79A4_B099);
    wr("ro_sw", B + 32'h0C, 32'hFFFF);
    wr("unmapped", B + 32'h1C, 32'hFFFF);
    rd("unmapped_rd", B + 32'h1C, 32'd0);

    // Switch synchroniser latency
    @(negedge clk);
    switchs = 10'h155;
    rd("sw_c0", B + 32'h0C, 32'd0);
    tick(1);
    rd("sw_c1", B + 32'h0C, 32'd0);
    tick(1);
    rd("sw_c2", B + 32'h0C, 32'h155);

    // Short glitch is rejected
    @(negedge clk);
    buttons[1] = 1'b0;
    tick(DEB - 2);
    buttons[1] = 1'b1;
    tick(DEB + 4);
    rd("btn_glitch", B + 32'h10, 32'd0);
    rd("edge_glitch", B + 32'h14, 32'd0);

    // Long press accepted
    buttons[1] = 1'b0;
    tick(DEB + 3);
    rd("btn_press", B + 32'h10, 32'h2);
    rd("edge_press", B + 32'h14, 32'h2);
    buttons[1] = 1'b1;
    tick(DEB + 6);
    rd("btn_release", B + 32'h10, 32'd0);
    rd("edge_sticky", B + 32'h14, 32'h2);
    wr("w1c", B + 32'h14, 32'h2);
    rd("edge_cleared", B + 32'h14, 32'd0);

    // Press completing on the same edge as a W1C write keeps the flag
    @(negedge clk);
    buttons[1] = 1'b0;
    tick(DEB + 1);
    rd("btn_before_flip", B + 32'h10, 32'd0);
    addr = B + 32'h14; wdata = 32'h2; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd("btn_after_flip", B + 32'h10, 32'h2);
    rd("edge_coincident", B + 32'h14, 32'h2);

    // Timer
`ifdef DE0_MMIO_TIMER_EN
    wr("timer_wr", B + 32'h18, 32'hFFFF_FFFE);
    addr = B + 32'h18;
    @(negedge clk);
    rd("timer_t0", B + 32'h18, 32'hFFFF_FFFF);
    tick(1);
    rd("timer_wrap", B + 32'h18, 32'd0);
    tick(1);
    rd("timer_t2", B + 32'h18, 32'd1);
`else
    wr("timer_wr", B + 32'h18, 32'hFFFF_FFFE);
    rd("timer_off", B + 32'h18, 32'd0);
`endif

    // Outside the window: ram write, no I/O change
    @(negedge clk);
    addr = 32'h0000_0100; wdata = 32'hFFFF_FFFF; we = 1'b1; #1;
    check("out_sel", {31'd0, sel}, 32'd0);
    check("out_ram_we", {31'd0, ram_we}, 32'd1);
    @(negedge clk);
    we = 1'b0;
    rd("out_led", B, 32'h3A5);
    rd("out_hex", B + 32'h04, 32'h1234);

    // Reset in the middle of a debounce (button still held from above)
    buttons[1] = 1'b1;
    tick(DEB + 6);
    buttons[0] = 1'b0;
    tick(4);
    rst_n = 1'b0; #1;
    check("mid_rst_leds", {22'd0, leds}, 32'd0);
    check("mid_rst_segs", segs, 32'hFFFF_FFFF);
    rd("mid_rst_hex", B + 32'h04, 32'd0);
    rd("mid_rst_edge", B + 32'h14, 32'd0);
    rd("mid_rst_sw", B + 32'h0C, 32'd0);
    buttons[0] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(DEB + 5);
    rd("post_rst_btn", B + 32'h10, 32'd0);
    rd("post_rst_edge", B + 32'h14, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/de0_mmio.md
Name: de0_mmio

Overview:
- Parametrised memory-mapped I/O block for the DE0 board top level.
- Sits between the CPU data port (aluresult/writedata/memwrite) and dmem.
- Claims a 256-byte address window and provides LED, multi-digit seven-segment, switch, debounced button, edge-flag and free-running timer registers.
- Gates dmem writes for addresses inside the window; the top-level muxes read data using sel.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, window base; only bits [31:8] are compared.
- NUM_LEDS, 10, LED register/output width (1..32).
- NUM_SW, 10, switch input width (1..32).
- NUM_BTN, 3, button input width (1..32).
- NUM_DIGITS, 4, seven-segment digit count (1..8).
- DEBOUNCE_CYCLES, 50000, stable cycles required before a button change is accepted (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  CPU data address
- wdata  in  32  CPU write data
- we  in  1  CPU write strobe
- rdata  out  32  I/O read data, combinational
- sel  out  1  addr[31:8]==BASE_ADDR[31:8]
- ram_we  out  1  we & ~sel, drives dmem write enable
- switchs  in  NUM_SW  raw board switches, asynchronous
- buttons  in  NUM_BTN  raw board buttons, active-low, asynchronous
- leds  out  NUM_LEDS  LED drive
- segs  out  8*NUM_DIGITS  active-low segments; digit k occupies [8k+7:8k], bit order {dp,g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Decode: the word offset is addr[7:2]. Writes commit on the rising clk edge when we & sel. Writes are word-only and byte lanes are ignored.
- Register map (byte offsets):
  - 0x00 LED RW [NUM_LEDS-1:0].
  - 0x04 HEX RW [4*NUM_DIGITS-1:0]; nibble k drives digit k.
  - 0x08 HEX_CTRL RW; bit0 = display enable; bits[NUM_DIGITS:1] = per-digit dp.
  - 0x0C SW RO; synchronised switches.
  - 0x10 BTN RO; debounced buttons, 1 = pressed.
  - 0x14 BTN_EDGE R/W1C; sticky press flags.
  - 0x18 TIMER RW.
- Unmapped offsets read 0. Writes to RO or unmapped offsets are ignored. Unused upper bits read 0.
- rdata is combinational from the current register state. A read in the same cycle as a write to that register returns the pre-write value.
- Reset values:
  - LED, HEX, HEX_CTRL, TIMER and BTN_EDGE are 0.
  - The switch synchroniser is 0.
  - The button synchroniser is all 1 (released); debounced state 0; debounce counters 0.
  - leds = 0; segs = all 1 (display off).
- Synchronisers: 2-FF on switchs and buttons. The synchronised buttons are inverted to active-high. Input-to-SW register latency is 2 cycles.
- Debounce, per button:
  - If the synced value != debounced state, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge flags:
  - BTN_EDGE[i] sets on a debounced 0->1 transition of button i.
  - Writing 1 to bit i clears it.
  - A set and a clear in the same cycle leave the flag set.
- Seven-segment:
  - Hex decode covers 0-F with standard patterns, active-low (0 -> 8'b1100_0000 with dp off).
  - dp is active-low from HEX_CTRL.
  - With enable = 0, every digit output is 8'hFF.
  - Outputs are combinational from the registers.
- Timer:
  - Increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - On a write, TIMER <= wdata (the write wins over the increment), and increments resume the next cycle.
- Reset mid-operation clears everything asynchronously; pending debounce progress is lost.

Optional Feature:
- DE0_MMIO_TIMER_EN defined: the TIMER register is implemented as above.
- DE0_MMIO_TIMER_EN undefined: no counter logic is built, offset 0x18 reads 0, and writes to it are ignored.

Test Plan:
- Reset, then read all offsets -> all return 0; leds = 0; segs = all 8'hFF; ram_we follows we only outside the window.
- Write 0x3A5 to 0x00, then 0x1234 to 0x04, then 0x03 to 0x08 -> leds = 10'h3A5; digit0 = ~dp with pattern '4' (8'b0001_1001); digits 1-3 show 3, 2, 1; sel = 1 and ram_we = 0 on each write.
- Set switchs = 10'h155 -> SW reads 0 for 2 cycles, then 0x155.
- Drive button1 low for DEBOUNCE_CYCLES-2 cycles, then high -> BTN stays 0. Drive low for DEBOUNCE_CYCLES+3 cycles -> BTN = 0x2 and BTN_EDGE = 0x2. Write 0x2 to 0x14 -> reads 0. A second press coincident with the W1C write -> flag remains 1.
- With the macro defined: write 0xFFFF_FFFE to 0x18 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0 on successive cycles. Without the macro: reads 0.
- Address 0x0000_0100 with we = 1 -> sel = 0, ram_we = 1, no I/O register changes. Assert rst_n low mid-debounce -> all registers return to reset values immediately.
